dram_rascas_ctrl: RTL and testbench

//  Sequences one bank of page-less DRAM behind the row/column address

---
 rtl/dram_ctrl_pkg.sv | 24 ++
 rtl/dram_refresh_timer.sv | 61 ++++++
 rtl/dram_rascas_ctrl.sv | 132 +++++++++++++
 tb/tb_dram_rascas_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the RAS/CAS DRAM controller: FSM state encoding,
// default timing parameters and a small sizing helper.
package dram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_RAS,
    ST_CPU_CAS,
    ST_REF,
    ST_PRE
  } state_t;

  localparam int DEF_ROW_BITS   = 8;
  localparam int DEF_RAS_CYC    = 2;
  localparam int DEF_CAS_CYC    = 2;
  localparam int DEF_PRE_CYC    = 2;
  localparam int DEF_REF_PERIOD = 234;

  // Larger of two phase lengths; sizes the shared phase down-counter.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval timer, pending/overrun flags and refresh row counter.
// The FSM pulses ref_take on the edge it enters REF and ref_done on the
// edge it leaves REF.
module dram_refresh_timer
  import dram_ctrl_pkg::*;
#(
  parameter int ROW_BITS   = DEF_ROW_BITS,
  parameter int REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ref_take,
  input  logic                ref_done,
  output logic                ref_req,
  output logic [ROW_BITS-1:0] row,
  output logic                ref_overrun
);

  localparam int TW = $clog2(REF_PERIOD);

  logic [TW-1:0] timer;
  logic          ref_pend;
  logic          tick;

  assign tick = (timer == TW'(REF_PERIOD - 1));

  // The terminal-count edge already counts as a request, so a CPU request
  // arriving on that same IDLE edge loses to the refresh.
  assign ref_req = ref_pend | tick;

  // Free-running interval counter 0..REF_PERIOD-1.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     timer <= '0;
    else if (tick) timer <= '0;
    else           timer <= timer + TW'(1);
  end

  // Pending flag: a tick sets it unless that same tick is being consumed by
  // entering REF from a clear flag; a tick on an edge that takes an older
  // pending refresh leaves one new refresh pending (set wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ref_pend <= 1'b0;
    else if (tick)     ref_pend <= ref_pend | ~ref_take;
    else if (ref_take) ref_pend <= 1'b0;
  end

  // Sticky overrun: a tick lands while an unserviced refresh is still waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            ref_overrun <= 1'b0;
    else if (tick && ref_pend && !ref_take) ref_overrun <= 1'b1;
  end

  // Refresh row advances after each completed refresh, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         row <= '0;
    else if (ref_done) row <= row + ROW_BITS'(1);
  end

endmodule

// File: rtl/dram_rascas_ctrl.sv
// RAS/CAS sequencer for one bank of page-less DRAM behind quad 2:1 address
// selectors. Arbitrates CPU accesses against RAS-only refresh; all outputs
// are registered from the next-state decode so they change on the same edge
// as the state.
module dram_rascas_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int ROW_BITS   = DEF_ROW_BITS,
  parameter int RAS_CYC    = DEF_RAS_CYC,
  parameter int CAS_CYC    = DEF_CAS_CYC,
  parameter int PRE_CYC    = DEF_PRE_CYC,
  parameter int REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  output logic                ack,
  output logic                ras_n,
  output logic                cas_n,
  output logic                we_n,
  output logic                addrsel,
  output logic                mux_g,
  output logic [ROW_BITS-1:0] ref_addr,
  output logic                ref_overrun
);

  localparam int PH_W = $clog2(max2(RAS_CYC + CAS_CYC, PRE_CYC)) + 1;

  state_t              state, state_nxt;
  logic [PH_W-1:0]     phase, phase_nxt;
  logic                we_lat, we_nxt;
  logic                ref_req, ref_take, ref_done;
  logic [ROW_BITS-1:0] row;
  logic                arb, last, cpu_nxt;

  dram_refresh_timer #(
    .ROW_BITS  (ROW_BITS),
    .REF_PERIOD(REF_PERIOD)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .ref_take   (ref_take),
    .ref_done   (ref_done),
    .ref_req    (ref_req),
    .row        (row),
    .ref_overrun(ref_overrun)
  );

  assign last = (phase == '0);
  // The final precharge edge doubles as an arbitration edge, so a waiting
  // request starts right after tRP without an extra idle clock.
  assign arb  = (state == ST_IDLE) || ((state == ST_PRE) && last);

  // Next state, phase count and refresh handshake.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    ref_take  = 1'b0;
    ref_done  = 1'b0;
    we_nxt    = we_lat;
    if (!last) phase_nxt = phase - PH_W'(1);
    case (state)
      ST_CPU_RAS: if (last) begin
        state_nxt = ST_CPU_CAS;
        phase_nxt = PH_W'(CAS_CYC - 1);
      end
      ST_CPU_CAS: if (last) begin
        state_nxt = ST_PRE;
        phase_nxt = PH_W'(PRE_CYC - 1);
      end
      ST_REF: if (last) begin
        state_nxt = ST_PRE;
        phase_nxt = PH_W'(PRE_CYC - 1);
        ref_done  = 1'b1;
      end
      default: ;
    endcase
    if (arb) begin
      if (ref_req) begin
        state_nxt = ST_REF;
        phase_nxt = PH_W'(RAS_CYC + CAS_CYC - 1);
        ref_take  = 1'b1;
      end else if (req) begin
        state_nxt = ST_CPU_RAS;
        phase_nxt = PH_W'(RAS_CYC - 1);
        we_nxt    = we;
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  assign cpu_nxt = (state_nxt == ST_CPU_RAS) || (state_nxt == ST_CPU_CAS);

  // State, phase counter and latched write flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      phase  <= '0;
      we_lat <= 1'b0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      we_lat <= we_nxt;
    end
  end

  // Registered pin outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_n    <= 1'b1;
      cas_n    <= 1'b1;
      we_n     <= 1'b1;
      addrsel  <= 1'b0;
      mux_g    <= 1'b0;
      ack      <= 1'b0;
      ref_addr <= '0;
    end else begin
      ras_n    <= !(cpu_nxt || (state_nxt == ST_REF));
      cas_n    <= (state_nxt != ST_CPU_CAS);
      we_n     <= cpu_nxt ? ~we_nxt : 1'b1;
      addrsel  <= (state_nxt == ST_CPU_CAS);
      mux_g    <= cpu_nxt;
      ack      <= (state_nxt == ST_CPU_CAS) && (phase_nxt == '0);
      ref_addr <= (state_nxt == ST_REF) ? row : '0;
    end
  end

endmodule

// File: tb/tb_dram_rascas_ctrl.sv
// Self-checking bench for dram_rascas_ctrl with REF_PERIOD=16 and default
// timing. After each reset release the next rising edge is edge 0; the first
// refresh tick lands on edge 15.
module tb_dram_rascas_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req, we;
  logic       ack, ras_n, cas_n, we_n, addrsel, mux_g, ref_overrun;
  logic [7:0] ref_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = -1;

  always #5 clk = ~clk;

  dram_rascas_ctrl #(
    .ROW_BITS  (8),
    .RAS_CYC   (2),
    .CAS_CYC   (2),
    .PRE_CYC   (2),
    .REF_PERIOD(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .ack        (ack),
    .ras_n      (ras_n),
    .cas_n      (cas_n),
    .we_n       (we_n),
    .addrsel    (addrsel),
    .mux_g      (mux_g),
    .ref_addr   (ref_addr),
    .ref_overrun(ref_overrun)
  );

  // {req, we} _ {ras_n, cas_n, we_n} _ {addrsel, mux_g, ack}
  typedef struct packed {
    logic req;
    logic we;
    logic ras_n;
    logic cas_n;
    logic we_n;
    logic addrsel;
    logic mux_g;
    logic ack;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    req   = 1'b0;
    we    = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ras_n", 32'(ras_n), 1);
    check("rst_cas_n", 32'(cas_n), 1);
    check("rst_we_n", 32'(we_n), 1);
    check("rst_mux_g", 32'(mux_g), 0);
    check("rst_addrsel", 32'(addrsel), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_ref_addr", 32'(ref_addr), 0);
    check("rst_overrun", 32'(ref_overrun), 0);
    reset = 1'b0;
    cyc   = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idle_bad;
    int   got;
    int   last_edge;
    int   bad;
    logic found;
    logic prev_ras;
    logic [7:0] kk;

    // Read at edge 0, then a write held from the ack cycle onward.
    vecs[0]  = 8'b10_011_010;
    vecs[1]  = 8'b10_011_010;
    vecs[2]  = 8'b10_001_110;
    vecs[3]  = 8'b10_001_111;
    vecs[4]  = 8'b11_111_000;
    vecs[5]  = 8'b11_111_000;
    vecs[6]  = 8'b11_010_010;
    vecs[7]  = 8'b10_010_010;
    vecs[8]  = 8'b00_000_110;
    vecs[9]  = 8'b00_000_111;
    vecs[10] = 8'b00_111_000;
    vecs[11] = 8'b00_111_000;
    vecs[12] = 8'b00_111_000;
    vecs[13] = 8'b00_111_000;
    vecs[14] = 8'b00_111_000;

    // Test 1: reset, then 10 idle clocks.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("idle%0d_ras_n", i), 32'(ras_n), 1);
      check($sformatf("idle%0d_cas_n", i), 32'(cas_n), 1);
      check($sformatf("idle%0d_we_n", i), 32'(we_n), 1);
      check($sformatf("idle%0d_mux_g", i), 32'(mux_g), 0);
      check($sformatf("idle%0d_ref_addr", i), 32'(ref_addr), 0);
    end

    // Tests 2/3: read then write from the vector table (edges 0..14).
    do_reset();
    for (int i = 0; i < 15; i++) begin
      req = vecs[i].req;
      we  = vecs[i].we;
      step();
      check($sformatf("v%0d_ras_n", i), 32'(ras_n), 32'(vecs[i].ras_n));
      check($sformatf("v%0d_cas_n", i), 32'(cas_n), 32'(vecs[i].cas_n));
      check($sformatf("v%0d_we_n", i), 32'(we_n), 32'(vecs[i].we_n));
      check($sformatf("v%0d_addrsel", i), 32'(addrsel), 32'(vecs[i].addrsel));
      check($sformatf("v%0d_mux_g", i), 32'(mux_g), 32'(vecs[i].mux_g));
      check($sformatf("v%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
      check($sformatf("v%0d_ref_addr", i), 32'(ref_addr), 0);
    end

    // Test 4: periodic refresh, row sequence and wrap after 256 refreshes.
    do_reset();
    prev_ras  = ras_n;
    last_edge = -1;
    bad       = 0;
    for (int k = 0; k < 257; k++) begin
      found = 1'b0;
      for (int t = 0; t < 40 && !found; t++) begin
        prev_ras = ras_n;
        step();
        if (!ras_n && (cas_n !== 1'b1 || mux_g !== 1'b0)) bad++;
        if (prev_ras && !ras_n) found = 1'b1;
      end
      check($sformatf("ref%0d_found", k), 32'(found), 1);
      if (found) begin
        kk = 8'(k);
        check($sformatf("ref%0d_addr", k), 32'(ref_addr), 32'(kk));
        check($sformatf("ref%0d_edge", k), cyc, (k == 0) ? 15 : last_edge + 16);
        last_edge = cyc;
      end
    end
    check("ref_strobes_during_ref", bad, 0);
    check("ref_overrun_t4", 32'(ref_overrun), 0);

    // Test 5: request and refresh tick on the same IDLE edge.
    do_reset();
    for (int i = 0; i < 15; i++) step();
    req = 1'b1;
    we  = 1'b0;
    step();
    check("t5_ref_ras_n", 32'(ras_n), 0);
    check("t5_ref_cas_n", 32'(cas_n), 1);
    check("t5_ref_mux_g", 32'(mux_g), 0);
    check("t5_ref_addr", 32'(ref_addr), 0);
    got = -1;
    for (int t = 0; t < 20 && got < 0; t++) begin
      step();
      if (ack) got = cyc;
    end
    check("t5_ack_edge", got, 24);
    req = 1'b0;
    step();
    check("t5_post_ras_n", 32'(ras_n), 1);
    check("t5_post_ack", 32'(ack), 0);
    check("t5_overrun", 32'(ref_overrun), 0);

    // Test 6: async reset during CPU_CAS after one refresh has advanced the row.
    do_reset();
    for (int i = 0; i < 22; i++) step();
    req = 1'b1;
    we  = 1'b1;
    repeat (3) step();
    check("t6_in_cas", 32'(cas_n), 0);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_ras_n", 32'(ras_n), 1);
    check("t6_async_cas_n", 32'(cas_n), 1);
    check("t6_async_we_n", 32'(we_n), 1);
    check("t6_async_mux_g", 32'(mux_g), 0);
    check("t6_async_ack", 32'(ack), 0);
    step();
    check("t6_no_ack", 32'(ack), 0);
    check("t6_held_ras_n", 32'(ras_n), 1);
    req   = 1'b0;
    we    = 1'b0;
    reset = 1'b0;
    cyc   = -1;
    idle_bad = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (ras_n !== 1'b1 || cas_n !== 1'b1 || mux_g !== 1'b0 || ack !== 1'b0) idle_bad++;
    end
    check("t6_idle_after_reset", idle_bad, 0);
    step();
    check("t6_ref_ras_n", 32'(ras_n), 0);
    check("t6_row_reset", 32'(ref_addr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
